xor_accum_arbiter: RTL
======================

Name: xor_accum_arbiter

Overview:
Shares one 32-bit bitwise XOR datapath between two burst requesters. Each requester streams a burst of 32-bit words, and the block returns the XOR-fold of that burst, tagged with the requester ID and the beat count. Arbitration is round-robin at burst granularity. Sits between packet/checksum producers and the shared XOR unit in the datapath.

Parameters:
WIDTH, 32, data/accumulator width (only 32 is supported)
MAXLEN, 16, maximum beats per burst before forced termination
CNT_W, 5, beat-counter width = clog2(MAXLEN+1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 beat valid
req0_ready  out  1  requester 0 beat accepted
req0_data  in  WIDTH  requester 0 word
req0_last  in  1  requester 0 final beat of burst
req1_valid  in  1  requester 1 beat valid
req1_ready  out  1  requester 1 beat accepted
req1_data  in  WIDTH  requester 1 word
req1_last  in  1  requester 1 final beat of burst
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_data  out  WIDTH  XOR of all accepted beats in the burst
res_id  out  1  granted requester (0/1)
res_count  out  CNT_W  beats accepted, range 1..MAXLEN
res_trunc  out  1  burst terminated at MAXLEN without last
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync-safe deassert is handled upstream) forces:
  - state=IDLE; acc=0; cnt=0; grant=0; last_grant=1, so requester 0 wins the first tie.
  - All outputs 0: res_valid=0, res_data=0, res_id=0, res_count=0, res_trunc=0, req*_ready=0, busy=0.
- Reset mid-burst or mid-result aborts the operation. The partial result is discarded and never presented.
- States: IDLE, ACCUM, RESP.
- IDLE:
  - Both readies are 0.
  - If any reqN_valid=1: register grant (tie goes to the requester != last_grant, else the sole valid one), clear acc=0 and cnt=0, then go to ACCUM.
  - Arbitration costs 1 cycle. No beat is accepted in IDLE.
- ACCUM:
  - req_ready of the granted requester is 1; the other is 0.
  - Beat = valid && ready. On a beat: acc <= acc XOR data, via the XOR sub-module; cnt <= cnt+1.
  - Ungranted requester valid is ignored. Its data must be held per valid/ready rules, and it is served next.
  - Beat with last=1: go to RESP, res_trunc=0.
  - Beat with last=0 where cnt+1 == MAXLEN: go to RESP, res_trunc=1. Subsequent beats from that requester form a new burst.
  - A cycle with valid=0 leaves acc and cnt unchanged (bubbles allowed).
- RESP:
  - res_valid=1. res_data/res_id/res_count/res_trunc are registered and stable until the handshake.
  - Both readies are 0.
  - On res_valid && res_ready: last_grant <= grant, res_valid <= 0, go to IDLE.
  - No result is ever dropped; back-pressure stalls both requesters.
- Latency: the first beat is accepted 1 cycle after valid is seen in IDLE. res_valid rises the cycle after the final beat.
- Minimum burst turnaround: beats + 2 cycles (+ res_ready wait).
- Zero-length bursts are impossible, so res_count >= 1.
- XOR width: WIDTH bits, no carry. acc XOR 0 == acc.

Decomposition:
- Shared package xor_arb_pkg:
  - state enum {IDLE=2'd0, ACCUM=2'd1, RESP=2'd2}
  - WIDTH and MAXLEN defaults
  - requester-ID typedef
- One sub-module: a bitwiseXOR32 instance computing acc XOR selected data.
- The mux of req0/req1 data by grant is local logic, not a sub-module.

Test Plan:
- Single burst, req0 only: words 0xFFFF0000, 0x0F0F0F0F, last on 0x00000001. Expect res_data=0xF0F00F0E, res_id=0, res_count=3, res_trunc=0, res_valid one cycle after the last beat.
- Simultaneous req0 and req1 valid after reset. Expect req0 granted first and req1 ready=0 throughout. After req0's result handshake, req1 is granted; a second tie then goes to req0 again (alternation).
- Overlong burst: 17 beats of 0x00000001 with no last. Expect the first result res_count=16, res_data=0, res_trunc=1. The 17th beat is a new burst: res_count=1, res_data=0x00000001.
- Back-pressure: hold res_ready=0 for 5 cycles in RESP. Expect res_* stable, both readies 0, no beats lost. The result handshakes on the cycle res_ready=1.
- Bubbles: req1 sends 0xA5A5A5A5, then valid=0 for 3 cycles, then 0x5A5A5A5A with last. Expect res_data=0xFFFFFFFF, res_count=2, res_id=1.
- Reset asserted mid-ACCUM after 2 beats. Expect all outputs 0 immediately (async). After release, a new 1-beat burst 0x12345678 returns exactly 0x12345678 with count 1.

Source files
------------

// File: rtl/xor_accum_arbiter_pkg.sv
// Shared types and constants for the burst XOR-fold arbiter.
package xor_arb_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned MAXLEN = 16;
  localparam int unsigned CNT_W  = $clog2(MAXLEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/xor_accum_arbiter_if.sv
// Requester, result and status signals of the XOR-fold arbiter.
interface xor_accum_arbiter_if;
  import xor_arb_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic             req0_last;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic             req1_last;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_id;
  logic [CNT_W-1:0] res_count;
  logic             res_trunc;
  logic             busy;

  modport master (
    output req0_valid, req0_data, req0_last,
    input  req0_ready,
    output req1_valid, req1_data, req1_last,
    input  req1_ready,
    output res_ready,
    input  res_valid, res_data, res_id, res_count, res_trunc, busy
  );

  modport slave (
    input  req0_valid, req0_data, req0_last,
    output req0_ready,
    input  req1_valid, req1_data, req1_last,
    output req1_ready,
    input  res_ready,
    output res_valid, res_data, res_id, res_count, res_trunc, busy
  );

endinterface

// File: rtl/xor_accum_arbiter_xor.sv
// Carry-free bitwise XOR of the accumulator and the selected beat.
module bitwiseXOR32
  import xor_arb_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = a_i ^ b_i;

endmodule

// File: rtl/xor_accum_arbiter.sv
// Round-robin, burst-granular arbiter folding each requester burst through one XOR unit.
module xor_accum_arbiter
  import xor_arb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  xor_accum_arbiter_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_id_t          grant_q, grant_d;
  req_id_t          last_grant_q, last_grant_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  req_id_t          res_id_q, res_id_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic             res_trunc_q, res_trunc_d;

  logic             sel_valid;
  logic             sel_last;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] xor_y;
  logic [CNT_W-1:0] cnt_inc;

  assign sel_valid = grant_q ? bus.req1_valid : bus.req0_valid;
  assign sel_last  = grant_q ? bus.req1_last  : bus.req0_last;
  assign sel_data  = grant_q ? bus.req1_data  : bus.req0_data;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  bitwiseXOR32 u_xor (
    .a_i (acc_q),
    .b_i (sel_data),
    .y_o (xor_y)
  );

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_id_d     = res_id_q;
    res_count_d  = res_count_q;
    res_trunc_d  = res_trunc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          // Tie goes to whoever was not served last; otherwise the sole requester.
          grant_d = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (sel_valid) begin
          acc_d = xor_y;
          cnt_d = cnt_inc;
          if (sel_last || (cnt_inc == CNT_W'(MAXLEN))) begin
            state_d     = RESP;
            res_valid_d = 1'b1;
            res_data_d  = xor_y;
            res_id_d    = grant_q;
            res_count_d = cnt_inc;
            res_trunc_d = ~sel_last;
          end
        end
      end
      RESP: begin
        if (bus.res_ready) begin
          res_valid_d  = 1'b0;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_id_q     <= 1'b0;
      res_count_q  <= '0;
      res_trunc_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_id_q     <= res_id_d;
      res_count_q  <= res_count_d;
      res_trunc_q  <= res_trunc_d;
    end
  end

  assign bus.req0_ready = (state_q == ACCUM) && !grant_q;
  assign bus.req1_ready = (state_q == ACCUM) &&  grant_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_id     = res_id_q;
  assign bus.res_count  = res_count_q;
  assign bus.res_trunc  = res_trunc_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
